// File: rtl/fw_rv_pack_if.sv
// Narrow-in / wide-out ready/valid bundle for fw_rv_pack.
// FW_RV_PACK_LAST_EN adds i_last and o_keep.
interface fw_rv_pack_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) ();
  logic [WIDTH-1:0]       i_dat;
  logic                   i_valid;
  logic                   i_ready;
  logic [WIDTH*RATIO-1:0] o_dat;
  logic                   o_valid;
  logic                   o_ready;
`ifdef FW_RV_PACK_LAST_EN
  logic                   i_last;
  logic [RATIO-1:0]       o_keep;

  modport master (output i_dat, i_valid, i_last, o_ready,
                  input  i_ready, o_dat, o_valid, o_keep);
  modport slave  (input  i_dat, i_valid, i_last, o_ready,
                  output i_ready, o_dat, o_valid, o_keep);
`else
  modport master (output i_dat, i_valid, o_ready,
                  input  i_ready, o_dat, o_valid);
  modport slave  (input  i_dat, i_valid, o_ready,
                  output i_ready, o_dat, o_valid);
`endif
endinterface

// File: rtl/fw_rv_pack.sv
// Ready/valid upsizer: packs RATIO narrow beats little-endian into one wide beat.
// FW_RV_PACK_LAST_EN enables early word close on i_last with an o_keep lane mask.
module fw_rv_pack #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input logic         clock,
  input logic         reset_n,
  fw_rv_pack_if.slave bus
);
  localparam int CW = $clog2(RATIO);
  localparam int AW = WIDTH * (RATIO - 1);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WIDTH*RATIO-1:0] dat_q, dat_d;
  logic                   vld_q, vld_d;
  logic [RATIO-1:0]       keep_q, keep_d;
  logic                   last_s, close_s, fire_s, out_free_s;

`ifdef FW_RV_PACK_LAST_EN
  assign last_s = bus.i_last;
  assign bus.o_keep = keep_q;
`else
  assign last_s = 1'b0;
`endif

  // A closing beat needs the output register empty or draining this cycle.
  assign out_free_s  = !vld_q || bus.o_ready;
  assign close_s     = (cnt_q == LAST_LANE) || last_s;
  assign bus.i_ready = !close_s || out_free_s;
  assign fire_s      = bus.i_valid && bus.i_ready;
  assign bus.o_dat   = dat_q;
  assign bus.o_valid = vld_q;

  // Next-state: accumulate open lanes, or load the wide register on close.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dat_d  = dat_q;
    keep_d = keep_q;
    if (vld_q && bus.o_ready) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
    if (fire_s && close_s) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (CW'(k) < cnt_q) begin
          dat_d[k*WIDTH +: WIDTH] = acc_q[k*WIDTH +: WIDTH];
        end else if (CW'(k) == cnt_q) begin
          dat_d[k*WIDTH +: WIDTH] = bus.i_dat;
        end else begin
          dat_d[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        end
      end
      if (cnt_q == LAST_LANE) begin
        dat_d[(RATIO-1)*WIDTH +: WIDTH] = bus.i_dat;
      end else begin
        dat_d[(RATIO-1)*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
      for (int k = 0; k < RATIO; k++) begin
        keep_d[k] = (CW'(k) <= cnt_q);
      end
      vld_d = 1'b1;
      cnt_d = {CW{1'b0}};
    end else if (fire_s) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (CW'(k) == cnt_q) begin
          acc_d[k*WIDTH +: WIDTH] = bus.i_dat;
        end else begin
          acc_d[k*WIDTH +: WIDTH] = acc_q[k*WIDTH +: WIDTH];
        end
      end
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= {CW{1'b0}};
      acc_q  <= {AW{1'b0}};
      dat_q  <= {(WIDTH*RATIO){1'b0}};
      vld_q  <= 1'b0;
      keep_q <= {RATIO{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      keep_q <= keep_d;
    end
  end
endmodule

// File: tb/tb_fw_rv_pack.sv
// Self-checking bench for fw_rv_pack: queue-based packing model plus directed literal checks.
module tb_fw_rv_pack;
  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fw_rv_pack_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();
  fw_rv_pack #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: accepted beats in order, words pending on the output, words observed.
  logic [WIDTH-1:0]       part[$];
  logic [WIDTH*RATIO-1:0] exp_dat[$];
  logic [RATIO-1:0]       exp_keep[$];
  logic [WIDTH*RATIO-1:0] got_q[$];
  int                     got_t[$];
  logic [WIDTH*RATIO-1:0] w;
  logic [RATIO-1:0]       kp;
  logic                   last_v;
  logic                   exp_rdy;

  always @(negedge clock) begin
    if (!reset_n) begin
      part.delete();
      exp_dat.delete();
      exp_keep.delete();
    end else begin
`ifdef FW_RV_PACK_LAST_EN
      last_v = bus.i_last;
`else
      last_v = 1'b0;
`endif
      exp_rdy = ((part.size() != RATIO - 1) && !last_v) || (exp_dat.size() == 0) || bus.o_ready;
      check("o_valid", {63'd0, bus.o_valid}, {63'd0, exp_dat.size() != 0});
      check("i_ready", {63'd0, bus.i_ready}, {63'd0, exp_rdy});
      if (bus.o_valid && bus.o_ready) begin
        if (exp_dat.size() == 0) begin
          check("unexpected_word", 64'(exp_dat.size()), 64'd1);
        end else begin
          check("o_dat", 64'(bus.o_dat), 64'(exp_dat[0]));
`ifdef FW_RV_PACK_LAST_EN
          check("o_keep", 64'(bus.o_keep), 64'(exp_keep[0]));
`endif
          got_q.push_back(bus.o_dat);
          got_t.push_back(cyc);
          void'(exp_dat.pop_front());
          void'(exp_keep.pop_front());
        end
      end
      if (bus.i_valid && bus.i_ready) begin
        part.push_back(bus.i_dat);
        if (part.size() == RATIO || last_v) begin
          w  = '0;
          kp = '0;
          foreach (part[k]) begin
            w[k*WIDTH +: WIDTH] = part[k];
            kp[k] = 1'b1;
          end
          exp_dat.push_back(w);
          exp_keep.push_back(kp);
          part.delete();
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n;
    bus.i_dat   = d;
    bus.i_valid = 1'b1;
`ifdef FW_RV_PACK_LAST_EN
    bus.i_last  = l;
`else
    if (l) bus.i_dat = d;
`endif
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.i_ready && n < 200);
    if (!bus.i_ready) check("send_timeout", {63'd0, bus.i_ready}, 64'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
`ifdef FW_RV_PACK_LAST_EN
    bus.i_last  = 1'b0;
`endif
  endtask

  initial begin
    int  beats;
    logic fire;
    reset_n     = 1'b0;
    bus.i_dat   = '0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
`ifdef FW_RV_PACK_LAST_EN
    bus.i_last  = 1'b0;
`endif
    #3;
    check("rst_o_valid", {63'd0, bus.o_valid}, 64'd0);
    check("rst_i_ready", {63'd0, bus.i_ready}, 64'd1);
    check("rst_o_dat", 64'(bus.o_dat), 64'd0);
    #9 reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic pack
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    idle();
    @(negedge clock);
    check("basic_valid", {63'd0, bus.o_valid}, 64'd1);
    check("basic_dat", 64'(bus.o_dat), 64'h44332211);
    @(negedge clock);
    check("basic_one_cycle", {63'd0, bus.o_valid}, 64'd0);

    // Streaming
    @(posedge clock); #1;
    got_q.delete(); got_t.delete();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    idle();
    repeat (3) @(posedge clock); #1;
    check("stream_words", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      check("stream_w0", 64'(got_q[0]), 64'h03020100);
      check("stream_w1", 64'(got_q[1]), 64'h07060504);
      check("stream_w2", 64'(got_q[2]), 64'h0B0A0908);
      check("stream_w3", 64'(got_q[3]), 64'h0F0E0D0C);
      for (int i = 0; i < 3; i++) check("stream_spacing", 64'(got_t[i+1] - got_t[i]), 64'd4);
    end

    // Backpressure
    bus.o_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 7; i++) send(8'(i), 1'b0);
    bus.i_dat   = 8'h07;
    bus.i_valid = 1'b1;
    @(negedge clock);
    check("bp_stall_ready", {63'd0, bus.i_ready}, 64'd0);
    check("bp_hold_dat", 64'(bus.o_dat), 64'h03020100);
    @(posedge clock); #1;
    @(negedge clock);
    check("bp_hold_dat2", 64'(bus.o_dat), 64'h03020100);
    @(posedge clock); #1;
    bus.o_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", {63'd0, bus.i_ready}, 64'd1);
    @(posedge clock); #1;
    idle();
    @(negedge clock);
    check("bp_no_bubble_valid", {63'd0, bus.o_valid}, 64'd1);
    check("bp_no_bubble_dat", 64'(bus.o_dat), 64'h07060504);
    @(posedge clock); #1;
    check("bp_first_word", 64'(got_q[0]), 64'h03020100);

    // Reset mid-word
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    idle();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_o_valid", {63'd0, bus.o_valid}, 64'd0);
    check("midrst_i_ready", {63'd0, bus.i_ready}, 64'd1);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    idle();
    @(negedge clock);
    check("midrst_dat", 64'(bus.o_dat), 64'h04030201);
    @(posedge clock); #1;

`ifdef FW_RV_PACK_LAST_EN
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    idle();
    @(negedge clock);
    check("last_dat", 64'(bus.o_dat), 64'h00002211);
    check("last_keep", 64'(bus.o_keep), 64'h3);
    @(posedge clock); #1;
    send(8'h33, 1'b0); send(8'h34, 1'b0); send(8'h35, 1'b0); send(8'h36, 1'b0);
    idle();
    @(negedge clock);
    check("last_next_dat", 64'(bus.o_dat), 64'h36353433);
    check("last_next_keep", 64'(bus.o_keep), 64'hF);
    @(posedge clock); #1;
`endif

    // Random stall
    beats = 0;
    for (int c = 0; c < 40000 && beats < 10000; c++) begin
      @(negedge clock);
      fire = bus.i_valid && bus.i_ready;
      if (fire) beats++;
      @(posedge clock); #1;
      if (fire || !bus.i_valid) begin
        bus.i_valid = ($urandom_range(0, 3) != 0);
        bus.i_dat   = 8'($urandom_range(0, 255));
`ifdef FW_RV_PACK_LAST_EN
        bus.i_last  = ($urandom_range(0, 4) == 0);
`endif
      end
      bus.o_ready = ($urandom_range(0, 3) != 0);
    end
    check("random_beats", 64'(beats), 64'd10000);
    idle();
    bus.o_ready = 1'b1;
    repeat (3) @(posedge clock); #1;
    check("drain_empty", 64'(exp_dat.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
